// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor. A request loads both operands and a
//   borrow-in, then one bit per clock is pushed through a one-bit full
//   subtractor, LSB first. After WIDTH shift cycles the block enters FIN. It
//   pulses DONE for one cycle there and then returns to IDLE.
//
// Parameters
//   WIDTH        operand/result width in bits (2..32)
//
// Ports
//   CLK          in   rising-edge clock
//   RST_N        in   asynchronous active-low reset
//   START        in   request, sampled only while IDLE
//   A            in   minuend (unsigned, WIDTH bits)
//   B            in   subtrahend (unsigned, WIDTH bits)
//   BI           in   borrow-in
//   BUSY         out  high whenever the FSM is not IDLE
//   DONE         out  one-cycle completion strobe (state FIN)
//   D            out  A - B - BI mod 2^WIDTH, valid from DONE onward
//   BO           out  final borrow-out, 1 iff A < B + BI
//   dbg_state_o  out  current FSM state encoding (0 IDLE, 1 SHIFT, 2 FIN)
//
// Handshake: START is a level request. It is accepted on any rising edge
// where the FSM is IDLE and START=1. While BUSY=1, START is ignored and is
// not queued. DONE is a single-cycle strobe with no acknowledge. D and BO
// hold their values from DONE until shifting of the next accepted operation
// begins.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic             bor_q;    // running borrow between bit positions
  logic             bo_q;     // published borrow-out, updated only at the end
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  // One-bit full subtractor on the current LSBs of the operand shifters.
  logic bit_a;
  logic bit_b;
  logic diff_bit_d;
  logic bor_d;

  assign bit_a      = a_q[0];
  assign bit_b      = b_q[0];
  assign diff_bit_d = bit_a ^ bit_b ^ bor_q;
  assign bor_d      = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bor_q);

  // The running borrow and the published BO are separate registers. Loading
  // BI at the start edge must not disturb the previous result on BO.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      bor_q   <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            a_q     <= A;
            b_q     <= B;
            bor_q   <= BI;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          bor_q <= bor_d;
          // Result enters at the MSB and moves right, so after WIDTH shifts
          // the first (LSB) difference bit sits at D[0].
          d_q   <= {diff_bit_d, d_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            bo_q    <= bor_d;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end

        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign D           = d_q;
  assign BO          = bo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH=8. Expected results come
//   from plain integer arithmetic: diff = A - B - BI. D is diff mod 256, and BO
//   is diff < 0. The expected results pass through a queue to the DONE point.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BI;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] D;
  logic         BO;
  logic [1:0]   dbg_state;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .A          (A),
    .B          (B),
    .BI         (BI),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .D          (D),
    .BO         (BO),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int           checks = 0;
  int           errors = 0;
  logic [W:0]   exp_q[$];      // {bo, d}
  logic [W-1:0] prev_d;
  logic         prev_bo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bi);
    longint     diff;
    logic [W:0] r;
    diff = longint'(a) - longint'(b) - longint'(bi);
    r[W-1:0] = diff[W-1:0];
    r[W]     = (diff < 0);
    return r;
  endfunction

  // ---------------------------------------------------------------- drivers
  // One operation: request on the next edge, then watch a fixed window. With
  // poke=1, extra START requests carrying other operands are raised at edges
  // 3, 8 and 9 after the load edge. None of them may be accepted.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit poke, input string tag);
    logic [W:0] exp;
    logic [W:0] got;
    int         lat;
    int         busy_cnt;
    int         done_cnt;
    exp_q.push_back(model(a, b, bi));
    @(negedge CLK);
    A = a; B = b; BI = bi; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = W'($urandom); B = W'($urandom); BI = 1'($urandom);
    lat = -1; busy_cnt = 0; done_cnt = 0; got = '0;
    for (int k = 0; k < W + 6; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        chk({tag, "_hold_d"},  D,  prev_d);
        chk({tag, "_hold_bo"}, BO, prev_bo);
      end
      if (poke) begin
        if (k == 2 || k == 7 || k == 8) begin
          START = 1'b1; A = 8'h00; B = 8'h01; BI = 1'b0;
        end else begin
          START = 1'b0;
        end
      end
      if (BUSY) busy_cnt++;
      if (DONE) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          got = {BO, D};
        end
      end
    end
    START = 1'b0;
    exp = exp_q.pop_front();
    chk({tag, "_latency"}, 64'(lat),      64'(W));
    chk({tag, "_busy"},    64'(busy_cnt), 64'(W + 1));
    chk({tag, "_dones"},   64'(done_cnt), 64'd1);
    chk({tag, "_d"},       got[W-1:0],    exp[W-1:0]);
    chk({tag, "_bo"},      got[W],        exp[W]);
    chk({tag, "_d_held"},  D,             exp[W-1:0]);
    chk({tag, "_bo_held"}, BO,            exp[W]);
    prev_d  = exp[W-1:0];
    prev_bo = exp[W];
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [W:0] e1;
    logic [W:0] e2;
    logic [W:0] g1;
    logic [W:0] g2;
    int         d1;
    int         d2;
    int         nd;

    RST_N = 1'b0; START = 1'b0; A = '0; B = '0; BI = 1'b0;
    prev_d = '0; prev_bo = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy",  BUSY,      1'b0);
    chk("rst_done",  DONE,      1'b0);
    chk("rst_d",     D,         8'h00);
    chk("rst_bo",    BO,        1'b0);
    chk("rst_state", dbg_state, 2'd0);
    RST_N = 1'b1;

    // Directed operand patterns.
    run_op(8'h05, 8'h03, 1'b0, 1'b0, "p05_03");
    run_op(8'h03, 8'h05, 1'b0, 1'b0, "p03_05");
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, "pff_ff");
    run_op(8'h00, 8'h00, 1'b1, 1'b0, "p00_00_bi");
    run_op(8'h80, 8'h7F, 1'b1, 1'b0, "p80_7f_bi");

    // START while busy (mid-shift and in FIN) is ignored.
    run_op(8'h10, 8'h01, 1'b0, 1'b1, "busy_start");

    // Reset in the middle of an operation.
    @(negedge CLK);
    A = W'($urandom_range(1, 255)); B = W'($urandom_range(0, 255)); BI = 1'b1; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_busy",  BUSY,      1'b0);
    chk("mid_rst_done",  DONE,      1'b0);
    chk("mid_rst_d",     D,         8'h00);
    chk("mid_rst_bo",    BO,        1'b0);
    chk("mid_rst_state", dbg_state, 2'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    nd = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge CLK);
      if (DONE) nd++;
    end
    chk("mid_rst_no_done", 64'(nd), 64'd0);
    prev_d = '0; prev_bo = 1'b0;
    run_op(8'h0A, 8'h04, 1'b0, 1'b0, "after_rst");

    // Back-to-back with START held high across both loads.
    e1 = model(8'h5A, 8'hC3, 1'b0);
    e2 = model(8'h21, 8'h20, 1'b1);
    @(negedge CLK);
    A = 8'h5A; B = 8'hC3; BI = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1;
    A = 8'h21; B = 8'h20; BI = 1'b1;
    d1 = -1; d2 = -1; nd = 0; g1 = '0; g2 = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (k == 10) START = 1'b0;
      if (DONE) begin
        nd++;
        if (d1 < 0) begin
          d1 = k; g1 = {BO, D};
        end else if (d2 < 0) begin
          d2 = k; g2 = {BO, D};
        end
      end
    end
    chk("b2b_first_lat", 64'(d1),      64'(W));
    chk("b2b_period",    64'(d2 - d1), 64'(W + 2));
    chk("b2b_dones",     64'(nd),      64'd2);
    chk("b2b_d1",        g1,           e1);
    chk("b2b_d2",        g2,           e2);
    prev_d = e2[W-1:0]; prev_bo = e2[W];

    // Randomized operands.
    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: CLK  input  1  rising-edge clock.
REQ-003 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: START  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: A  input  WIDTH  minuend, unsigned.
REQ-006 SHALL have port: B  input  WIDTH  subtrahend, unsigned.
REQ-007 SHALL have port: BI  input  1  borrow-in.
REQ-008 SHALL have port: BUSY  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port: DONE  output  1  single-cycle completion strobe.
REQ-010 SHALL have port: D  output  WIDTH  difference A-B-BI mod 2^WIDTH.
REQ-011 SHALL have port: BO  output  1  final borrow-out; 1 iff A < B+BI.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, FIN, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-013 SHALL, in IDLE with START=1 at a rising edge: capture A, B into internal shift registers, load the borrow flop from BI, clear the counter, and go to SHIFT.
REQ-014 SHALL, in IDLE with START=0, stay in IDLE with all registers unchanged.
REQ-015 SHALL, on each SHIFT edge, process one bit LSB-first through a one-bit full subtractor.
REQ-016 SHALL compute the difference bit d = a^b^bor in SHIFT.
REQ-017 SHALL compute the next borrow bor' = (~a&b) | (~(a^b)&bor) in SHIFT.
REQ-018 SHALL, on each SHIFT edge, shift d into the result register MSB with the register moving right, and increment the counter.
REQ-019 SHALL, on the SHIFT edge that processes bit WIDTH-1, go to FIN; D then holds the full result and BO the final borrow.
REQ-020 SHALL, in FIN, assert DONE=1 for exactly one cycle and go to IDLE on the next edge regardless of START.
REQ-021 SHALL assert DONE first WIDTH cycles after the START-sampling edge: edges 1..WIDTH shift, and FIN is entered at edge WIDTH.
REQ-022 SHALL hold D and BO stable from FIN entry until the next accepted START edge, where they are not updated until shifting.
REQ-023 SHALL allow D to show partial shift contents while BUSY=1; D/BO are valid only from DONE onward.
REQ-024 SHALL ignore START while BUSY=1, including in FIN, with no queuing; A/B/BI changes after the load edge have no effect.
REQ-025 SHALL accept START in the first IDLE cycle after FIN, giving a back-to-back period of WIDTH+2 cycles.
REQ-026 SHALL produce BO with no distinct overflow signal, since unsigned wrap is expressed by BO.

Reset
REQ-027 SHALL, while RST_N=0, immediately force state IDLE, BUSY=0, DONE=0, D=0, BO=0, counter=0, and operand/borrow registers=0.
REQ-028 SHALL, on reset assertion mid-operation, abort the operation with no DONE pulse; the first START after release starts a fresh operation.
REQ-029 SHALL leave the block in IDLE after RST_N deasserts; START may be accepted on the first rising edge with RST_N=1.

Verification (WIDTH=8)
REQ-030 SHALL verify: A=0x05, B=0x03, BI=0, START pulse -> DONE exactly 8 cycles after the start edge, D=0x02, BO=0, BUSY high for 9 cycles.
REQ-031 SHALL verify: A=0x03, B=0x05, BI=0 -> D=0xFE, BO=1; A=0xFF, B=0xFF, BI=0 -> D=0x00, BO=0.
REQ-032 SHALL verify: A=0x00, B=0x00, BI=1 -> D=0xFF, BO=1; A=0x80, B=0x7F, BI=1 -> D=0x00, BO=0.
REQ-033 SHALL verify: START with A=0x10, B=0x01, then START with A=0x00, B=0x01 at cycles 3 and 8 (FIN) -> single DONE, D=0x0F, BO=0.
REQ-034 SHALL verify: RST_N low for 1 cycle at cycle 4 of an operation -> BUSY/DONE/D/BO=0 asynchronously, no DONE; next START with A=0x0A, B=0x04 -> D=0x06, BO=0.
REQ-035 SHALL verify: two back-to-back operations with START held high continuously -> second load on the first IDLE edge after FIN, DONE pulses 10 cycles apart.
